// File: rtl/gate_bist_pkg.sv
// Shared definitions for the 2-input gate BIST checker.
// - state_e : controller state encoding (idle, gap, settle, done)
// - TT_*    : expected truth tables, indexed by vector v = {Input_B, Input_A}
// - max_u   : helper for sizing the shared timer
package gate_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGap,
        StSettle,
        StDone
    } state_e;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gate_bist_checker_if.sv
// Signal bundle between the gate BIST checker and its environment.
// - Start, Gate_Out        : request and gate-under-test output (into the checker)
// - Input_A, Input_B       : stimulus to the gate under test
// - Busy, Done, Pass       : run status
// - Error_Count, Fail_Vector : result of the last run
// master modport is the checker side; slave modport is the environment side.
interface gate_bist_checker_if;

    logic       Start;
    logic       Gate_Out;
    logic       Input_A;
    logic       Input_B;
    logic       Busy;
    logic       Done;
    logic       Pass;
    logic [2:0] Error_Count;
    logic [3:0] Fail_Vector;

    modport master (
        input  Start,
        input  Gate_Out,
        output Input_A,
        output Input_B,
        output Busy,
        output Done,
        output Pass,
        output Error_Count,
        output Fail_Vector
    );

    modport slave (
        output Start,
        output Gate_Out,
        input  Input_A,
        input  Input_B,
        input  Busy,
        input  Done,
        input  Pass,
        input  Error_Count,
        input  Fail_Vector
    );

endinterface

// File: rtl/gate_bist_timer.sv
// Loadable down-counter shared by the gap and settle phases.
// - clk_i, rst_ni : clock and asynchronous active-low reset
// - load_i        : load load_val_i (has priority over en_i)
// - en_i          : decrement while non-zero
// - zero_o        : count is zero
module gate_bist_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/gate_bist_checker.sv
// On-chip stimulus/response checker for a 2-input combinational gate.
// Walks v = 0..3 (Input_A = v[0], Input_B = v[1]); each vector is preceded by
// GAP_CYCLES idle cycles and held SETTLE_CYCLES cycles before Gate_Out is
// compared with EXPECTED_TT[v].
// - Clk, Reset_n : clock and asynchronous active-low reset
// - bus (master) : Start/Gate_Out in; stimulus, status and results out
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int unsigned GAP_CYCLES    = 100,
    parameter int unsigned SETTLE_CYCLES = 20,
    parameter logic [3:0]  EXPECTED_TT   = TT_AND
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    gate_bist_checker_if.master   bus
);

    localparam int unsigned TimerW = $clog2(max_u(GAP_CYCLES, SETTLE_CYCLES)) + 1;
    localparam logic [TimerW-1:0] GapLoad    = TimerW'(GAP_CYCLES - 1);
    localparam logic [TimerW-1:0] SettleLoad = TimerW'(SETTLE_CYCLES - 1);

    state_e      state_d, state_q;
    logic [1:0]  v_d, v_q;
    logic        in_a_d, in_a_q;
    logic        in_b_d, in_b_q;
    logic        pass_d, pass_q;
    logic [2:0]  err_cnt_d, err_cnt_q;
    logic [3:0]  fail_vec_d, fail_vec_q;

    logic              tmr_load;
    logic              tmr_en;
    logic [TimerW-1:0] tmr_val;
    logic              tmr_zero;
    logic              mismatch;

    gate_bist_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        in_a_d     = in_a_q;
        in_b_d     = in_b_q;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        fail_vec_d = fail_vec_q;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        tmr_val    = GapLoad;
        mismatch   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    state_d    = StGap;
                    v_d        = 2'd0;
                    tmr_load   = 1'b1;
                    err_cnt_d  = 3'd0;
                    fail_vec_d = 4'd0;
                    pass_d     = 1'b0;
                end
            end
            StGap: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    in_a_d   = v_q[0];
                    in_b_d   = v_q[1];
                    tmr_load = 1'b1;
                    tmr_val  = SettleLoad;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    mismatch = bus.Gate_Out ^ EXPECTED_TT[v_q];
                    if (mismatch) begin
                        fail_vec_d[v_q] = 1'b1;
                        // Saturate; at most four vectors can fail anyway.
                        err_cnt_d = (err_cnt_q == 3'd4) ? err_cnt_q : err_cnt_q + 3'd1;
                    end
                    if (v_q == 2'd3) begin
                        state_d = StDone;
                        in_a_d  = 1'b0;
                        in_b_d  = 1'b0;
                        pass_d  = (fail_vec_q == 4'd0) && !mismatch;
                    end else begin
                        v_d      = v_q + 2'd1;
                        tmr_load = 1'b1;
                        state_d  = StGap;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StIdle;
            v_q        <= 2'd0;
            in_a_q     <= 1'b0;
            in_b_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= 3'd0;
            fail_vec_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            in_a_q     <= in_a_d;
            in_b_q     <= in_b_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    assign bus.Input_A     = in_a_q;
    assign bus.Input_B     = in_b_q;
    assign bus.Busy        = (state_q == StGap) || (state_q == StSettle);
    assign bus.Done        = (state_q == StDone);
    assign bus.Pass        = pass_q;
    assign bus.Error_Count = err_cnt_q;
    assign bus.Fail_Vector = fail_vec_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Self-checking bench for gate_bist_checker with GAP_CYCLES=2, SETTLE_CYCLES=1
// and an AND expectation. The gate under test is a truth-table lookup driven
// from the DUT's Input_A/Input_B; expected results come from simple arithmetic
// on the gate and expected truth tables.
module tb_gate_bist_checker;
    import gate_bist_pkg::*;

    localparam int G = 2;
    localparam int S = 1;
    localparam int N = 4 * (G + S);
    localparam logic [3:0] EXP_TT = TT_AND;

    logic clk;
    logic rst_n;
    logic [3:0] gate_tt;

    gate_bist_checker_if bus ();

    assign bus.Gate_Out = gate_tt[{bus.Input_B, bus.Input_A}];

    gate_bist_checker #(
        .GAP_CYCLES    (G),
        .SETTLE_CYCLES (S),
        .EXPECTED_TT   (EXP_TT)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total;
    int n_pass;

    logic [1:0] obs_ab   [0:31];
    logic       obs_done [0:31];
    logic       obs_busy [0:31];
    logic       obs_pass [0:31];
    logic [2:0] obs_err  [0:31];
    logic [3:0] obs_fail [0:31];
    int         done_count;

    // Expected {Input_B, Input_A} in the cycle after edge k of a single run.
    function automatic logic [1:0] exp_ab(input int k);
        int v;
        if (k < G || k >= N) return 2'b00;
        v = (k - G) / (G + S);
        return v[1:0];
    endfunction

    // Pulse (or hold) Start and record outputs after each edge; k=0 is the
    // acceptance edge. Optional re-pulses land on edges 3 and 7.
    task automatic run_capture(input int n_edges, input bit repulse, input bit hold);
        @(negedge clk);
        bus.Start = 1'b1;
        done_count = 0;
        for (int k = 0; k <= n_edges; k++) begin
            @(negedge clk);
            obs_ab[k]   = {bus.Input_B, bus.Input_A};
            obs_done[k] = bus.Done;
            obs_busy[k] = bus.Busy;
            obs_pass[k] = bus.Pass;
            obs_err[k]  = bus.Error_Count;
            obs_fail[k] = bus.Fail_Vector;
            if (bus.Done) done_count++;
            if (hold) bus.Start = (k < n_edges - 2);
            else      bus.Start = repulse && (k == 2 || k == 6);
        end
        bus.Start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.Start = 1'b0;
        gate_tt = TT_AND;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus.Input_B, bus.Input_A, bus.Busy, bus.Done, bus.Pass} !== 5'b0)
            $display("FAIL reset_ctl: got %b want 00000",
                     {bus.Input_B, bus.Input_A, bus.Busy, bus.Done, bus.Pass});
        else n_pass++;
        n_total++;
        if (bus.Error_Count !== 3'd0 || bus.Fail_Vector !== 4'd0)
            $display("FAIL reset_res: got err=%0d fail=%b want 0/0000",
                     bus.Error_Count, bus.Fail_Vector);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_and_pass();
        gate_tt = TT_AND;
        run_capture(14, 1'b0, 1'b0);
        for (int k = 0; k <= 14; k++) begin
            n_total++;
            if (obs_ab[k] !== exp_ab(k) || obs_busy[k] !== (k < N) || obs_done[k] !== (k == N))
                $display("FAIL and_seq[%0d]: got ab=%b busy=%b done=%b want ab=%b busy=%b done=%b",
                         k, obs_ab[k], obs_busy[k], obs_done[k], exp_ab(k), (k < N), (k == N));
            else n_pass++;
        end
        n_total++;
        if (obs_pass[N] !== 1'b1 || obs_err[N] !== 3'd0 || obs_fail[N] !== 4'd0)
            $display("FAIL and_result: got pass=%b err=%0d fail=%b want 1/0/0000",
                     obs_pass[N], obs_err[N], obs_fail[N]);
        else n_pass++;
        n_total++;
        if (obs_pass[14] !== 1'b1)
            $display("FAIL and_pass_held: got %b want 1", obs_pass[14]);
        else n_pass++;
        n_total++;
        if (done_count != 1)
            $display("FAIL and_done_count: got %0d want 1", done_count);
        else n_pass++;
    endtask

    task automatic test_stuck_low();
        logic [3:0] ef;
        gate_tt = 4'b0000;
        ef = gate_tt ^ EXP_TT;
        run_capture(14, 1'b0, 1'b0);
        n_total++;
        if (obs_pass[N] !== 1'b0 || obs_err[N] !== 3'($countones(ef)) || obs_fail[N] !== ef)
            $display("FAIL stuck_low: got pass=%b err=%0d fail=%b want 0/%0d/%b",
                     obs_pass[N], obs_err[N], obs_fail[N], $countones(ef), ef);
        else n_pass++;
    endtask

    task automatic test_or_vs_and();
        logic [3:0] ef;
        gate_tt = TT_OR;
        ef = gate_tt ^ EXP_TT;
        run_capture(14, 1'b0, 1'b0);
        n_total++;
        if (obs_pass[N] !== 1'b0 || obs_err[N] !== 3'($countones(ef)) || obs_fail[N] !== ef)
            $display("FAIL or_vs_and: got pass=%b err=%0d fail=%b want 0/%0d/%b",
                     obs_pass[N], obs_err[N], obs_fail[N], $countones(ef), ef);
        else n_pass++;
        n_total++;
        if (obs_err[0] !== 3'd0 || obs_fail[0] !== 4'd0 || obs_pass[0] !== 1'b0)
            $display("FAIL or_accept_clear: got err=%0d fail=%b pass=%b want 0/0000/0",
                     obs_err[0], obs_fail[0], obs_pass[0]);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        gate_tt = TT_AND;
        run_capture(14, 1'b1, 1'b0);
        for (int k = 0; k <= 14; k++) begin
            n_total++;
            if (obs_done[k] !== (k == N) || obs_busy[k] !== (k < N))
                $display("FAIL ignore_seq[%0d]: got done=%b busy=%b want done=%b busy=%b",
                         k, obs_done[k], obs_busy[k], (k == N), (k < N));
            else n_pass++;
        end
        n_total++;
        if (done_count != 1)
            $display("FAIL ignore_done_count: got %0d want 1", done_count);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        gate_tt = TT_AND;
        @(negedge clk);
        bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        n_total++;
        if ({bus.Input_B, bus.Input_A, bus.Busy} !== 3'b011)
            $display("FAIL midrun_pre: got b/a/busy=%b want 011",
                     {bus.Input_B, bus.Input_A, bus.Busy});
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.Input_B, bus.Input_A, bus.Busy, bus.Done, bus.Pass} !== 5'b0 ||
            bus.Error_Count !== 3'd0 || bus.Fail_Vector !== 4'd0)
            $display("FAIL midrun_reset: got ctl=%b err=%0d fail=%b want 00000/0/0000",
                     {bus.Input_B, bus.Input_A, bus.Busy, bus.Done, bus.Pass},
                     bus.Error_Count, bus.Fail_Vector);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        run_capture(14, 1'b0, 1'b0);
        n_total++;
        if (obs_done[N] !== 1'b1 || obs_pass[N] !== 1'b1 || obs_err[N] !== 3'd0 ||
            obs_fail[N] !== 4'd0)
            $display("FAIL midrun_rerun: got done=%b pass=%b err=%0d fail=%b want 1/1/0/0000",
                     obs_done[N], obs_pass[N], obs_err[N], obs_fail[N]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit eb;
        gate_tt = TT_AND;
        run_capture(28, 1'b0, 1'b1);
        // Second run is accepted on edge N+2 (one cycle after Done).
        for (int k = 0; k <= 28; k++) begin
            eb = (k < N) || (k >= N + 2 && k < 2 * N + 2);
            n_total++;
            if (obs_busy[k] !== eb || obs_done[k] !== (k == N || k == 2 * N + 2))
                $display("FAIL b2b_seq[%0d]: got busy=%b done=%b want busy=%b done=%b",
                         k, obs_busy[k], obs_done[k], eb, (k == N || k == 2 * N + 2));
            else n_pass++;
        end
        n_total++;
        if (obs_pass[N] !== 1'b1 || obs_pass[N + 1] !== 1'b1 || obs_pass[N + 2] !== 1'b0)
            $display("FAIL b2b_pass_clear: got %b%b%b want 110",
                     obs_pass[N], obs_pass[N + 1], obs_pass[N + 2]);
        else n_pass++;
        n_total++;
        if (obs_pass[2 * N + 2] !== 1'b1 || done_count != 2)
            $display("FAIL b2b_second: got pass=%b dones=%0d want 1/2",
                     obs_pass[2 * N + 2], done_count);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] ef;
        for (int it = 0; it < 8; it++) begin
            gate_tt = 4'($urandom_range(0, 15));
            ef = gate_tt ^ EXP_TT;
            run_capture(14, 1'b0, 1'b0);
            n_total++;
            if (obs_done[N] !== 1'b1 || obs_fail[N] !== ef ||
                obs_err[N] !== 3'($countones(ef)) || obs_pass[N] !== (ef == 4'd0))
                $display("FAIL random[%0d] tt=%b: got done=%b fail=%b err=%0d pass=%b want 1/%b/%0d/%b",
                         it, gate_tt, obs_done[N], obs_fail[N], obs_err[N], obs_pass[N],
                         ef, $countones(ef), (ef == 4'd0));
            else n_pass++;
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        test_reset();
        test_and_pass();
        test_stuck_low();
        test_or_vs_and();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
